fpu_add_pipe_ctrl: RTL and testbench
====================================

Name: fpu_add_pipe_ctrl

Overview:
- Shadow control pipeline for the 3-stage FP adder: align (E1), calculate (E2), normalize (E3), plus a writeback register (WB).
- Tracks valid bit and destination FP register per stage.
- Detects RAW hazards for the decode stage and generates stall and forwarding selects.
- Drives the adder's pipeline enable and captures the adder's normalized result into the WB register for the FP register file.

Parameters:
- FR_AW, 5, FP register address width.
- DW, 32, FP data width.

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- freeze  in  1  global hold from the multi-cycle FP unit (div/sqrt busy); holds the entire FP pipeline
- id_valid  in  1  decode stage holds a real instruction
- id_fop  in  1  decode instruction is an FP add/sub issued to the adder
- id_fd  in  FR_AW  decode destination FP register
- id_fs  in  FR_AW  decode source fs
- id_ft  in  FR_AW  decode source ft
- id_use_fs  in  1  instruction reads fs
- id_use_ft  in  1  instruction reads ft
- fpu_s  in  DW  adder output (normalize stage result, valid in E3)
- fpu_e  out  1  adder register enable
- id_stall  out  1  freeze IF/ID, inject bubble into E1
- fwd_fs  out  2  fs operand select: 00 register file, 01 fpu_s, 10 wb_data
- fwd_ft  out  2  ft operand select, same encoding
- wb_we  out  1  FP register-file write enable
- wb_fd  out  FR_AW  write address
- wb_data  out  DW  write data
- busy  out  1  any of E1/E2/E3/WB valid

Behaviour:
- Reset (clrn=0, asynchronous):
  - e1/e2/e3/wb valid = 0; all dest fields = 0; wb_data = 0.
  - Outputs: wb_we=0, wb_fd=0, busy=0, fwd_*=00; id_stall=freeze.
  - The same clrn clears the adder's internal registers, so a reset mid-operation discards all in-flight ops, with no partial writeback.
- fpu_e = ~freeze, combinationally.
- Advance (posedge clk, freeze=0):
  - e1 <= {id_valid & id_fop & ~id_stall, id_fd}
  - e2 <= e1; e3 <= e2; wb <= e3
  - wb_data <= fpu_s
- Hold (freeze=1): all stage registers keep their values; wb_data holds.
- Latency: an op accepted at cycle t (E1) is in WB at t+3; wb_we is high during cycle t+3.
- Match definitions:
  - match_X(r) = X.valid & (X.fd == r). FP register 0 is a real register with no special case.
  - needs(r) = id_valid & use bit for r.
- Stall:
  - id_stall = freeze | hazard.
  - hazard = (needs(fs) & (match_e1(fs) | match_e2(fs))) | same condition for ft.
  - The result is not ready before E3.
- Forwarding, per source:
  - match_e3 gives 01, else match_wb gives 10, else 00. The younger stage wins.
  - Forwarding outputs are valid whenever id_valid, independent of id_stall.
- Simultaneous WB write and decode read of the same register: forward 10 takes precedence over the register file.
- Back-to-back dependent adds:
  - Dependent distance 1: 2 stall cycles, then forward 01.
  - Distance 2: 1 stall cycle, then forward 01.
  - Distance 3: no stall, forward 01.
  - Distance 4: no stall, forward 10.
- WAW: impossible with a fixed in-order latency; no check required.
- wb_we = wb.valid. During freeze it stays asserted with unchanged data; the repeated write is idempotent.
- busy = e1.valid | e2.valid | e3.valid | wb.valid.

Decomposition:
- Shared package:
  - FWD_RF=2'b00, FWD_E3=2'b01, FWD_WB=2'b10
  - FADD_STAGES=3
  - stage record typedef {valid, fd}
- Sub-module fpu_stage_slot: valid+dest register with enable, bubble input and async clear. Instantiated for E1, E2, E3 and WB; WB adds the data field.
- Hazard/forward compare: a function evaluated once per source.

Test Plan:
- Reset: assert clrn=0 mid-stream with 3 ops in flight -> valids/busy/wb_we = 0 immediately. After release there are no writes for 4 cycles, and fpu_e=1.
- Independent issue: add f1=f2+f3 at cycle 0, fpu_s=0x40400000 at cycle 2 -> wb_we=1, wb_fd=1, wb_data=0x40400000 at cycle 3. No stalls.
- RAW distance 1: add f4 at cycle 0, then an add reading fs=f4 -> id_stall=1 for cycles 1–2; at cycle 3 fwd_fs=01, id_stall=0.
- RAW distance 4 via WB: f5 producer, 3 unrelated ops, then a reader of ft=f5 -> fwd_ft=10, while wb_we=1 and wb_fd=5 in the same cycle. Also cover the dual-match case (E3 and WB both hold f5) -> fwd_ft=01.
- Freeze: assert freeze=1 for 5 cycles with ops in E1–E3 -> fpu_e=0, id_stall=1, stage contents and wb_data unchanged. After release, writebacks resume in original order with correct fd.
- f0 destination: producer writes f0, consumer reads f0 at distance 2 -> 1 stall cycle, then forward 01. There is no zero-register suppression.

Source files
------------

// File: rtl/fpu_add_pipe_ctrl_pkg.sv
// Shared definitions for the FP adder shadow control pipeline.
//   - Operand-select encodings used by the decode-stage forwarding muxes.
//   - Number of arithmetic stages in the adder (align, calculate, normalize).
//   - Stage record layout {valid, fd} for the default register-address width.
//   - fwd_pick: priority select between the normalize stage and writeback.
package fpu_add_pipe_ctrl_pkg;

    localparam int FR_AW_DEF   = 5;
    localparam int DW_DEF      = 32;
    localparam int FADD_STAGES = 3;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E3 = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [FR_AW_DEF-1:0] fd;
    } stage_t;

    // The normalize stage holds the younger result, so it wins over writeback.
    function automatic logic [1:0] fwd_pick(input logic m_e3, input logic m_wb);
        if (m_e3) begin
            return FWD_E3;
        end else if (m_wb) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/fpu_add_pipe_ctrl_slot.sv
// fpu_stage_slot: one stage of the shadow control pipeline.
// Holds a valid bit, a destination FP register and an optional data word.
// Ports:
//   clk, clrn        clock, asynchronous active-low clear
//   en               advance enable; when low every field holds
//   bubble           forces the captured valid bit to 0 (stall injection)
//   valid_in, fd_in, data_in   values captured when en is high
//   valid_q, fd_q, data_q      registered stage contents
module fpu_stage_slot #(
    parameter int FR_AW = 5,
    parameter int DW    = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en,
    input  logic             bubble,
    input  logic             valid_in,
    input  logic [FR_AW-1:0] fd_in,
    input  logic [DW-1:0]    data_in,
    output logic             valid_q,
    output logic [FR_AW-1:0] fd_q,
    output logic [DW-1:0]    data_q
);

    logic             valid_d;
    logic [FR_AW-1:0] fd_d;
    logic [DW-1:0]    data_d;

    always_comb begin
        valid_d = valid_q;
        fd_d    = fd_q;
        data_d  = data_q;
        if (en) begin
            valid_d = valid_in & ~bubble;
            fd_d    = fd_in;
            data_d  = data_in;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q <= 1'b0;
            fd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            fd_q    <= fd_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/fpu_add_pipe_ctrl.sv
// fpu_add_pipe_ctrl: shadow control pipeline for the 3-stage FP adder
// (E1 align, E2 calculate, E3 normalize) plus the writeback register.
// Tracks valid/destination per stage, raises RAW stalls for decode,
// produces operand forwarding selects, enables the adder's registers and
// captures the normalized result for the FP register file.
//
// Decode handshake: id_valid & id_fop is the offer, ~id_stall is the ready;
// the op enters E1 on the rising edge where offer and ready are both high.
//
// Ports:
//   clk, clrn               clock, asynchronous active-low reset
//   freeze                  global hold from the multi-cycle FP unit
//   id_valid, id_fop        decode holds an instruction / it is an FP add
//   id_fd, id_fs, id_ft     decode destination and sources
//   id_use_fs, id_use_ft    decode actually reads fs / ft
//   fpu_s                   adder normalize-stage result (valid in E3)
//   fpu_e                   adder register enable
//   id_stall                hold IF/ID and bubble E1
//   fwd_fs, fwd_ft          operand selects: 00 regfile, 01 fpu_s, 10 wb_data
//   wb_we, wb_fd, wb_data   FP register-file write port
//   busy                    any stage valid
module fpu_add_pipe_ctrl
    import fpu_add_pipe_ctrl_pkg::*;
#(
    parameter int FR_AW = 5,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             freeze,
    input  logic             id_valid,
    input  logic             id_fop,
    input  logic [FR_AW-1:0] id_fd,
    input  logic [FR_AW-1:0] id_fs,
    input  logic [FR_AW-1:0] id_ft,
    input  logic             id_use_fs,
    input  logic             id_use_ft,
    input  logic [DW-1:0]    fpu_s,
    output logic             fpu_e,
    output logic             id_stall,
    output logic [1:0]       fwd_fs,
    output logic [1:0]       fwd_ft,
    output logic             wb_we,
    output logic [FR_AW-1:0] wb_fd,
    output logic [DW-1:0]    wb_data,
    output logic             busy
);

    localparam int LAST = FADD_STAGES - 1;

    logic [FADD_STAGES-1:0] st_valid;
    logic [FR_AW-1:0]       st_fd [FADD_STAGES];
    logic [FADD_STAGES-1:0] st_unused_data;
    logic                   wb_valid;
    logic                   adv_en;
    logic                   hazard;
    logic [2:0]             chk_fs;
    logic [2:0]             chk_ft;

    assign adv_en = ~freeze;
    assign fpu_e  = adv_en;

    // Arithmetic stages: index 0 is E1, LAST is E3 (result on fpu_s).
    for (genvar i = 0; i < FADD_STAGES; i++) begin : g_stage
        if (i == 0) begin : g_e1
            fpu_stage_slot #(.FR_AW(FR_AW), .DW(1)) u_slot (
                .clk      (clk),
                .clrn     (clrn),
                .en       (adv_en),
                .bubble   (id_stall),
                .valid_in (id_valid & id_fop),
                .fd_in    (id_fd),
                .data_in  (1'b0),
                .valid_q  (st_valid[i]),
                .fd_q     (st_fd[i]),
                .data_q   (st_unused_data[i])
            );
        end else begin : g_en
            fpu_stage_slot #(.FR_AW(FR_AW), .DW(1)) u_slot (
                .clk      (clk),
                .clrn     (clrn),
                .en       (adv_en),
                .bubble   (1'b0),
                .valid_in (st_valid[i-1]),
                .fd_in    (st_fd[i-1]),
                .data_in  (1'b0),
                .valid_q  (st_valid[i]),
                .fd_q     (st_fd[i]),
                .data_q   (st_unused_data[i])
            );
        end
    end

    fpu_stage_slot #(.FR_AW(FR_AW), .DW(DW)) u_wb (
        .clk      (clk),
        .clrn     (clrn),
        .en       (adv_en),
        .bubble   (1'b0),
        .valid_in (st_valid[LAST]),
        .fd_in    (st_fd[LAST]),
        .data_in  (fpu_s),
        .valid_q  (wb_valid),
        .fd_q     (wb_fd),
        .data_q   (wb_data)
    );

    // Per-source compare: {stall needed, forward select}.
    // Results exist only from E3 onward, so any E1/E2 match must stall.
    function automatic logic [2:0] src_check(input logic [FR_AW-1:0] r,
                                             input logic             needs);
        logic       haz;
        logic [1:0] sel;
        haz = 1'b0;
        for (int i = 0; i < LAST; i++) begin
            haz = haz | (st_valid[i] & (st_fd[i] == r));
        end
        sel = fwd_pick(st_valid[LAST] & (st_fd[LAST] == r),
                       wb_valid & (wb_fd == r));
        return {needs & haz, sel};
    endfunction

    always_comb begin
        chk_fs = src_check(id_fs, id_valid & id_use_fs);
        chk_ft = src_check(id_ft, id_valid & id_use_ft);
        hazard = chk_fs[2] | chk_ft[2];
        fwd_fs = id_valid ? chk_fs[1:0] : FWD_RF;
        fwd_ft = id_valid ? chk_ft[1:0] : FWD_RF;
    end

    assign id_stall = freeze | hazard;
    assign wb_we    = wb_valid;
    assign busy     = (|st_valid) | wb_valid;

endmodule

// File: tb/tb_fpu_add_pipe_ctrl.sv
// Directed bench for fpu_add_pipe_ctrl. A stand-in adder drives fpu_s with
// BASE + (number of non-frozen edges so far); an op entering E1 after k
// advancing edges therefore writes back BASE + k + 3.
module tb_fpu_add_pipe_ctrl;

    localparam int          FR_AW = 5;
    localparam int          DW    = 32;
    localparam logic [31:0] BASE  = 32'h4040_0000;

    logic             clk;
    logic             clrn;
    logic             freeze;
    logic             id_valid;
    logic             id_fop;
    logic [FR_AW-1:0] id_fd;
    logic [FR_AW-1:0] id_fs;
    logic [FR_AW-1:0] id_ft;
    logic             id_use_fs;
    logic             id_use_ft;
    logic [DW-1:0]    fpu_s;
    logic             fpu_e;
    logic             id_stall;
    logic [1:0]       fwd_fs;
    logic [1:0]       fwd_ft;
    logic             wb_we;
    logic [FR_AW-1:0] wb_fd;
    logic [DW-1:0]    wb_data;
    logic             busy;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   adv      = 0;
    logic frz_at_edge = 1'b0;
    logic [FR_AW+DW-1:0] exp_q[$];
    logic [31:0] dmy;
    logic [31:0] d1;
    logic [31:0] d14;

    fpu_add_pipe_ctrl #(.FR_AW(FR_AW), .DW(DW)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .freeze    (freeze),
        .id_valid  (id_valid),
        .id_fop    (id_fop),
        .id_fd     (id_fd),
        .id_fs     (id_fs),
        .id_ft     (id_ft),
        .id_use_fs (id_use_fs),
        .id_use_ft (id_use_ft),
        .fpu_s     (fpu_s),
        .fpu_e     (fpu_e),
        .id_stall  (id_stall),
        .fwd_fs    (fwd_fs),
        .fwd_ft    (fwd_ft),
        .wb_we     (wb_we),
        .wb_fd     (wb_fd),
        .wb_data   (wb_data),
        .busy      (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: wait for the edge, then check any fresh writeback against
    // the scoreboard (frozen edges repeat the same write and are skipped).
    task automatic tick();
        logic [FR_AW+DW-1:0] e;
        frz_at_edge = freeze;
        @(posedge clk);
        if (!frz_at_edge) adv++;
        #1;
        fpu_s = BASE + 32'(adv);
        if (clrn && wb_we && !frz_at_edge) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 32'(wb_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_fd", 32'(wb_fd), 32'(e[FR_AW+DW-1:DW]));
                check("wb_data", wb_data, e[DW-1:0]);
            end
        end
    endtask

    // Present an FP add in decode; expect 'stalls' stall cycles, then the
    // given forward selects, then acceptance into E1.
    task automatic issue(input logic [4:0] fd, input logic [4:0] fs, input logic [4:0] ft,
                         input logic ufs, input logic uft, input int stalls,
                         input logic [1:0] efs, input logic [1:0] eft,
                         output logic [31:0] dexp);
        id_valid  = 1'b1;
        id_fop    = 1'b1;
        id_fd     = fd;
        id_fs     = fs;
        id_ft     = ft;
        id_use_fs = ufs;
        id_use_ft = uft;
        #1;
        for (int i = 0; i < stalls; i++) begin
            check("stall_on", 32'(id_stall), 32'd1);
            tick();
        end
        check("stall_off", 32'(id_stall), 32'd0);
        check("fwd_fs", 32'(fwd_fs), 32'(efs));
        check("fwd_ft", 32'(fwd_ft), 32'(eft));
        dexp = BASE + 32'(adv) + 32'd3;
        exp_q.push_back({fd, dexp});
        tick();
        id_valid = 1'b0;
        id_fop   = 1'b0;
    endtask

    task automatic filler(input logic [4:0] fd);
        logic [31:0] d;
        issue(fd, 5'd30, 5'd31, 1'b1, 1'b1, 0, 2'b00, 2'b00, d);
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    initial begin
        clrn = 1'b0; freeze = 1'b1; id_valid = 1'b0; id_fop = 1'b0;
        id_fd = '0; id_fs = '0; id_ft = '0; id_use_fs = 1'b0; id_use_ft = 1'b0;
        fpu_s = BASE;

        // Reset state
        #2;
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_fd", 32'(wb_fd), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fwd_fs", 32'(fwd_fs), 32'd0);
        check("rst_fwd_ft", 32'(fwd_ft), 32'd0);
        check("rst_stall_frz", 32'(id_stall), 32'd1);
        check("rst_fpu_e_frz", 32'(fpu_e), 32'd0);
        freeze = 1'b0;
        #1;
        check("rst_stall", 32'(id_stall), 32'd0);
        check("rst_fpu_e", 32'(fpu_e), 32'd1);
        #9 clrn = 1'b1;
        tick();

        // Independent issue: f1 = f2 + f3, write back 3 cycles after E1
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 0, 2'b00, 2'b00, d1);
        check("ind_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check("ind_we_c2", 32'(wb_we), 32'd0);
        tick();
        check("ind_we_c3", 32'(wb_we), 32'd1);
        check("ind_fd_c3", 32'(wb_fd), 32'd1);
        check("ind_data_c3", wb_data, d1);
        drain();

        // RAW distance 1: 2 stalls then forward from E3
        issue(5'd4, 5'd2, 5'd3, 1'b1, 1'b1, 0, 2'b00, 2'b00, dmy);
        issue(5'd6, 5'd4, 5'd7, 1'b1, 1'b1, 2, 2'b01, 2'b00, dmy);
        drain();

        // RAW distance 2: 1 stall then forward from E3
        issue(5'd8, 5'd2, 5'd3, 1'b1, 1'b1, 0, 2'b00, 2'b00, dmy);
        filler(5'd20);
        issue(5'd9, 5'd8, 5'd31, 1'b1, 1'b1, 1, 2'b01, 2'b00, dmy);
        drain();

        // RAW distance 3: no stall, forward from E3
        issue(5'd13, 5'd2, 5'd3, 1'b1, 1'b1, 0, 2'b00, 2'b00, dmy);
        filler(5'd21);
        filler(5'd22);
        issue(5'd10, 5'd31, 5'd13, 1'b1, 1'b1, 0, 2'b00, 2'b01, dmy);
        drain();

        // RAW distance 4: forward from WB while WB is writing f5
        issue(5'd5, 5'd2, 5'd3, 1'b1, 1'b1, 0, 2'b00, 2'b00, dmy);
        filler(5'd21);
        filler(5'd22);
        filler(5'd23);
        check("d4_wb_we", 32'(wb_we), 32'd1);
        check("d4_wb_fd", 32'(wb_fd), 32'd5);
        issue(5'd11, 5'd30, 5'd5, 1'b0, 1'b1, 0, 2'b00, 2'b10, dmy);
        drain();

        // Dual match: f5 in both E3 and WB, younger E3 wins
        issue(5'd5, 5'd2, 5'd3, 1'b1, 1'b1, 0, 2'b00, 2'b00, dmy);
        issue(5'd5, 5'd2, 5'd3, 1'b1, 1'b1, 0, 2'b00, 2'b00, dmy);
        filler(5'd21);
        filler(5'd22);
        issue(5'd12, 5'd30, 5'd5, 1'b1, 1'b1, 0, 2'b00, 2'b01, dmy);
        drain();

        // Freeze for 5 cycles with f14 in WB, f15 in E3, f16 in E2
        issue(5'd14, 5'd30, 5'd31, 1'b1, 1'b1, 0, 2'b00, 2'b00, d14);
        filler(5'd15);
        filler(5'd16);
        tick();
        freeze = 1'b1;
        id_valid = 1'b1; id_fop = 1'b0;
        id_fs = 5'd15; id_ft = 5'd14; id_use_fs = 1'b1; id_use_ft = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("frz_fpu_e", 32'(fpu_e), 32'd0);
            check("frz_stall", 32'(id_stall), 32'd1);
            check("frz_busy", 32'(busy), 32'd1);
            check("frz_wb_we", 32'(wb_we), 32'd1);
            check("frz_wb_fd", 32'(wb_fd), 32'd14);
            check("frz_wb_data", wb_data, d14);
            check("frz_fwd_e3", 32'(fwd_fs), 32'd1);
            check("frz_fwd_wb", 32'(fwd_ft), 32'd2);
            tick();
        end
        freeze = 1'b0;
        id_valid = 1'b0;
        #1;
        check("unfrz_fpu_e", 32'(fpu_e), 32'd1);
        drain();

        // f0 destination behaves like any register: 1 stall, forward 01
        issue(5'd0, 5'd2, 5'd3, 1'b1, 1'b1, 0, 2'b00, 2'b00, dmy);
        filler(5'd24);
        issue(5'd17, 5'd0, 5'd31, 1'b1, 1'b1, 1, 2'b01, 2'b00, dmy);
        drain();

        // Reset mid-stream with three ops in flight
        filler(5'd25);
        filler(5'd26);
        filler(5'd27);
        check("mid_busy_pre", 32'(busy), 32'd1);
        clrn = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_wb_we", 32'(wb_we), 32'd0);
        exp_q.delete();
        #2 clrn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_we", 32'(wb_we), 32'd0);
            check("post_rst_fpu_e", 32'(fpu_e), 32'd1);
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
